des_iter_ctrl: RTL and testbench
================================

DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request carries valid block, key and mode.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port in_data, input, [64:1]: input block; bit 64 is DES bit 1.
REQ-006 SHALL have port in_key, input, [64:1]: 64-bit key including parity bits; bit 64 is DES bit 1.
REQ-007 SHALL have port in_decrypt, input, 1 bit: 1 = decrypt, 0 = encrypt.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_data, output, [64:1]: result block in the same bit order as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high in ROUND and DONE states.

Function
REQ-012 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a request is accepted on a clock edge where in_valid && in_ready.
REQ-014 On acceptance, SHALL register {L,R} = IP(in_data), {C,D} = PC1(in_key), latch in_decrypt, set round counter to 1, and go to ROUND.
REQ-015 In ROUND, SHALL perform exactly one Feistel round per cycle: L' = R, R' = L ^ f(R, Kround), then increment the counter.
REQ-016 Encrypt key generation: each round SHALL rotate C and D left by s(i), register the result, and use Kround = PC2(rotated C,D).
REQ-017 Shift schedule: s(i) = 1 for i in {1, 2, 9, 16}; s(i) = 2 for all other rounds.
REQ-018 Decrypt key generation: round 1 SHALL use PC2(C,D) with no rotation; round i (2..16) SHALL rotate C and D right by s(18-i), register the result, and use PC2 of the rotated value.
REQ-019 Latched mode and key state SHALL be unaffected by in_* changes after acceptance.
REQ-020 On the edge completing round 16, SHALL register out_data = IP_inv({R16,L16}) and go to DONE.
REQ-021 out_valid SHALL be high exactly in DONE.
REQ-022 Latency: out_valid SHALL first be high 17 cycles after the acceptance edge.
REQ-023 In DONE, out_data SHALL be held stable until out_valid && out_ready, then return to IDLE.
REQ-024 After the handshake, in_ready SHALL be high on the following cycle; throughput is at most one block per 18 cycles.
REQ-025 The counter is 5 bits; the ROUND to DONE transition occurs only at count 16; no wrap beyond 16 is permitted.
REQ-026 in_valid in ROUND or DONE SHALL be ignored, with no state change and no loss of the current block.
REQ-027 out_ready in IDLE or ROUND SHALL have no effect.

Reset
REQ-028 While rst is high: state = IDLE, counter = 0, out_valid = 0, busy = 0, in_ready = 1, out_data = 0, all L/R/C/D registers = 0.
REQ-029 Assertion of rst mid-ROUND or in DONE SHALL discard the block immediately, without producing output.
REQ-030 The first request SHALL be accepted on the first edge after rst deasserts with in_valid high.

Verification
REQ-031 Encrypt in_key=133457799BBCDFF1, in_data=0123456789ABCDEF -> out_data=85E813540F0AB405, out_valid at acceptance+17.
REQ-032 Decrypt in_key=133457799BBCDFF1, in_data=85E813540F0AB405 -> out_data=0123456789ABCDEF.
REQ-033 Encrypt key=0, data=0 -> 8CA64DE9C1B123A7; change in_key/in_data/in_decrypt during rounds -> same result.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst at round 8 -> out_valid never rises; new request after reset yields the correct 85E813540F0AB405 at +17.
REQ-036 Run 100 random back-to-back encrypt-then-decrypt pairs -> round trip returns the original plaintext each time, matching a combinational DES reference model.

Source files
------------

// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one Feistel round per clock with the key schedule rotated in
// place (left for encrypt, right for decrypt), valid/ready request and result ports.
module des_iter_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic [64:1] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    // Valid/ready: a beat moves on a rising edge where valid && ready are both high;
    // until then the producer holds its payload (out_data is frozen while out_valid waits).
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int IPINV_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    // Eight S-boxes back to back, 64 entries each, row-major (row = outer bits).
    localparam logic [3:0] SBOX_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // Tables use DES numbering: entry n names source bit n, bit 1 is the MSB.
    function automatic logic [63:0] perm_ip(input logic [63:0] x, input logic inv);
        for (int i = 0; i < 64; i++)
            perm_ip[63-i] = inv ? x[64-IPINV_T[i]] : x[64-IP_T[i]];
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-PC2_T[i]];
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  b;
        int          idx;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            idx = j*64 + int'({b[5], b[0]})*16 + int'(b[4:1]);
            s[31-4*j -: 4] = SBOX_T[idx];
        end
        for (int i = 0; i < 32; i++) f_fn[31-i] = s[32-P_T[i]];
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d;
    logic [63:0] out_data_q, out_data_d;
    logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [27:0] c_rot, d_rot;
    logic        one_shift;
    logic [31:0] f_out;

    // Decrypt walks the schedule backwards: round i undoes encrypt shift s(18-i).
    always_comb begin
        one_shift = dec_q ? (cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'd16)
                          : (cnt_q == 5'd1 || cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'd16);
        c_rot = c_q;
        d_rot = d_q;
        if (!dec_q) begin
            c_rot = one_shift ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
            d_rot = one_shift ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
        end else if (cnt_q != 5'd1) begin
            c_rot = one_shift ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
            d_rot = one_shift ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
        end
        f_out = f_fn(r_q, perm_pc2({c_rot, d_rot}));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        dec_d      = dec_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: if (in_valid) begin
                {l_d, r_d} = perm_ip(in_data, 1'b0);
                {c_d, d_d} = perm_pc1(in_key);
                dec_d      = in_decrypt;
                cnt_d      = 5'd1;
                state_d    = ROUND;
            end
            ROUND: begin
                l_d = r_q;
                r_d = l_q ^ f_out;
                c_d = c_rot;
                d_d = d_rot;
                if (cnt_q == 5'd16) begin
                    // Final swap folded in: output is IP^-1(R16, L16).
                    out_data_d = perm_ip({l_q ^ f_out, r_q}, 1'b1);
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: if (out_ready) begin
                cnt_d   = 5'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            dec_q       <= dec_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed and randomised checks of des_iter_ctrl against known DES vectors and an
// independently structured DES reference model.
module tb_des_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
    logic [64:1] in_data = '0, in_key = '0;
    logic        in_ready, out_valid, busy;
    logic [64:1] out_data;
    logic [1:0]  dbg_state;

    int          n_total = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;

    des_iter_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference tables; IP^-1 and E are derived rather than tabulated.
    localparam int IP_TB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int P_TB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_TB [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_TB [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8,
        16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int CUM_TB [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};
    localparam logic [255:0] SB_TB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ref_ip(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y = '0;
        for (int i = 1; i <= 64; i++) begin
            if (!inv) y[64-i] = x[64-IP_TB[i-1]];
            else      y[64-IP_TB[i-1]] = x[64-i];
        end
        return y;
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  e;
        logic [31:0]  s, p;
        logic [5:0]   b;
        logic [255:0] box;
        int           idx;
        for (int i = 1; i <= 48; i++)
            e[48-i] = r[32-(((4*((i-1)/6) + (i-1)%6 + 31) % 32) + 1)];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            idx = 32'(b[5])*32 + 32'(b[0])*16 + 32'(b[4:1]);
            box = SB_TB[j];
            s[31-4*j -: 4] = box[255-4*idx -: 4];
        end
        for (int i = 1; i <= 32; i++) p[32-i] = s[32-P_TB[i-1]];
        return p;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                            input bit dec);
        logic [55:0] cd, tmp, cdi;
        logic [47:0] ks [16];
        logic [63:0] lr;
        logic [31:0] l, r, t;
        for (int i = 1; i <= 56; i++) cd[56-i] = key[64-PC1_TB[i-1]];
        for (int i = 0; i < 16; i++) begin
            tmp = {cd[55:28], cd[55:28]} << CUM_TB[i];
            cdi[55:28] = tmp[55:28];
            tmp = {cd[27:0], cd[27:0]} << CUM_TB[i];
            cdi[27:0] = tmp[55:28];
            for (int j = 1; j <= 48; j++) ks[i][48-j] = cdi[56-PC2_TB[j-1]];
        end
        lr = ref_ip(blk, 1'b0);
        l  = lr[63:32];
        r  = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ ref_f(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return ref_ip({r, l}, 1'b1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input logic [63:0] key, input logic [63:0] data, input logic dec);
        int n = 0;
        in_key = key; in_data = data; in_decrypt = dec; in_valid = 1'b1;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        check("ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts cycles with the request cycle as 0: first ROUND cycle is 1.
    task automatic collect(input bit noisy, output logic [63:0] res, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_key     = {$urandom, $urandom};
                in_data    = {$urandom, $urandom};
                in_decrypt = 1'($urandom_range(0, 1));
                in_valid   = 1'($urandom_range(0, 1));
                out_ready  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        res = out_data;
    endtask

    task automatic finish_block();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_handshake", 64'(in_ready), 64'd1);
        check("valid_after_handshake", 64'(out_valid), 64'd0);
    endtask

    task automatic run_dir(input string tag, input logic [63:0] key, input logic [63:0] data,
                           input logic dec, input logic [63:0] exp, input bit noisy);
        logic [63:0] res;
        int          lat;
        send(key, data, dec);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        collect(noisy, res, lat);
        check({tag, "_lat"}, 64'(lat), 64'd17);
        check({tag, "_data"}, res, exp);
        check({tag, "_state_done"}, 64'(dbg_state), 64'd2);
        finish_block();
    endtask

    initial begin
        logic [63:0] res, res2, key, pt;
        int          lat;
        bit          seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // Release reset with a request already waiting: accepted on the next edge.
        rst = 1'b0;
        run_dir("enc1", KEY1, PT1, 1'b0, CT1, 1'b0);
        run_dir("dec1", KEY1, CT1, 1'b1, PT1, 1'b0);
        run_dir("zero_noisy", 64'd0, 64'd0, 1'b0, CT0, 1'b1);

        // Result held in DONE while the consumer stalls.
        send(KEY1, PT1, 1'b0);
        collect(1'b0, res, lat);
        check("hold_first", res, CT1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            in_data  = {$urandom, $urandom};
            in_key   = {$urandom, $urandom};
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, CT1);
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        finish_block();
        check("hold_idle_state", 64'(dbg_state), 64'd0);
        check("hold_idle_busy", 64'(busy), 64'd0);

        // Reset during round 8 drops the block with no output.
        send(KEY1, PT1, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_dir("after_rst", KEY1, PT1, 1'b0, CT1, 1'b0);

        // Random encrypt/decrypt round trips, back to back.
        for (int p = 0; p < 100; p++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            exp_q.push_back(des_ref(key, pt, 1'b0));
            send(key, pt, 1'b0);
            collect(1'b0, res, lat);
            check("rand_enc_lat", 64'(lat), 64'd17);
            check("rand_enc", res, exp_q.pop_front());
            finish_block();
            exp_q.push_back(pt);
            send(key, res, 1'b1);
            collect(1'b0, res2, lat);
            check("rand_dec", res2, exp_q.pop_front());
            finish_block();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
